// File: rtl/map9_pkg.sv
`timescale 1ns/1ps
// map9_pkg: widths, state type and timer width shared by the map9 requester files.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package map9_pkg;

    localparam int MAP9_N_W    = 9;
    localparam int MAP9_DP_W   = 9;
    localparam int MAP9_WAIT_W = 16;

    // One request at a time: accept, strobe start, wait for the mapper to
    // drop done (it has seen the new run), wait for done, then hand back.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        CLEAR = 3'd2,
        BUSY  = 3'd3,
        RESP  = 3'd4
    } map9_state_e;

endpackage

// File: rtl/map9_requester_if.sv
`timescale 1ns/1ps
// map9_requester_if: command, mapper and response signals of the map9 requester.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready upstream, rsp_valid/rsp_ready downstream.
interface map9_requester_if;
    import map9_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [MAP9_N_W-1:0]  cmd_n;
    logic                 start;
    logic [MAP9_N_W-1:0]  N;
    logic                 done;
    logic [MAP9_DP_W-1:0] dp;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [MAP9_DP_W-1:0] rsp_dp;
    logic                 rsp_timeout;

    // Requester side
    modport master (
        input  cmd_valid, cmd_n, done, dp, rsp_ready,
        output cmd_ready, start, N, rsp_valid, rsp_dp, rsp_timeout
    );

    // Upstream source / mapper / response sink side
    modport slave (
        output cmd_valid, cmd_n, done, dp, rsp_ready,
        input  cmd_ready, start, N, rsp_valid, rsp_dp, rsp_timeout
    );

endinterface

// File: rtl/map9_wait_timer.sv
`timescale 1ns/1ps
// map9_wait_timer: saturating 16-bit wait counter with synchronous clear and enable.
// Latency: expired is combinational from the count; count updates one cycle after en.
// Backpressure: none; the counter holds at all-ones rather than wrapping.
module map9_wait_timer
    import map9_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Count value on the cycle whose edge takes the counter to TIMEOUT_CYCLES.
    localparam logic [MAP9_WAIT_W-1:0] LAST = MAP9_WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MAP9_WAIT_W-1:0] ONE  = MAP9_WAIT_W'(1);

    logic [MAP9_WAIT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count while enabled and stop at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Raised while waiting on the last cycle before the count reaches the limit,
    // so the owner leaves on the same edge the counter gets there.
    assign expired = en && (cnt_q >= LAST);

endmodule

// File: rtl/map9_requester.sv
`timescale 1ns/1ps
// map9_requester: hands one 9-bit operand at a time to the map9 mapper and returns its result.
// Latency: START_CYCLES of start, then until done (or timeout); one mandatory IDLE cycle between requests.
// Backpressure: cmd_ready only in IDLE; the response is held in RESP until rsp_ready.
// Build option: define MAP9_REQUESTER_TIMEOUT_EN to add the wait timer and timeout abort.
module map9_requester
    import map9_pkg::*;
#(
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               rst,
    map9_requester_if.master   bus
);

    localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

    map9_state_e          state_q, state_d;
    logic [3:0]           start_cnt_q, start_cnt_d;
    logic [MAP9_N_W-1:0]  n_q, n_d;
    logic [MAP9_DP_W-1:0] rsp_dp_q, rsp_dp_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 timeout_hit;

`ifdef MAP9_REQUESTER_TIMEOUT_EN
    logic timer_clr;
    logic timer_en;

    // Restart the wait count on the edge that enters CLEAR; count through CLEAR and BUSY.
    assign timer_clr = (state_q == START) && (start_cnt_q == 4'd0);
    assign timer_en  = (state_q == CLEAR) || (state_q == BUSY);

    map9_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timeout_hit)
    );

    assign bus.rsp_timeout = rsp_timeout_q;
`else
    // Without the timer the requester waits on the mapper forever.
    assign timeout_hit     = 1'b0;
    assign bus.rsp_timeout = 1'b0;

    wire unused_timeout_cfg = ^{rsp_timeout_q, 16'(TIMEOUT_CYCLES)};
`endif

    // Next state, start pacing, operand capture and result capture.
    always_comb begin
        state_d       = state_q;
        start_cnt_d   = start_cnt_q;
        n_d           = n_q;
        rsp_dp_d      = rsp_dp_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    n_d         = bus.cmd_n;
                    start_cnt_d = START_LAST;
                    state_d     = START;
                end
            end
            START: begin
                if (start_cnt_q == 4'd0) begin
                    state_d = CLEAR;
                end else begin
                    start_cnt_d = start_cnt_q - 4'd1;
                end
            end
            CLEAR: begin
                // done still high here is the previous run's flag; wait for it to drop.
                if (timeout_hit) begin
                    rsp_dp_d      = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else if (!bus.done) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A real result beats a timeout landing on the same edge.
                if (bus.done) begin
                    rsp_dp_d      = bus.dp;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_dp_d      = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            start_cnt_q   <= 4'd0;
            n_q           <= '0;
            rsp_dp_q      <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_cnt_q   <= start_cnt_d;
            n_q           <= n_d;
            rsp_dp_q      <= rsp_dp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Handshake and strobe outputs decode straight from the registered state.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.start     = (state_q == START);
    assign bus.N         = n_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_dp    = rsp_dp_q;

endmodule

// File: tb/tb_map9_requester.sv
`timescale 1ns/1ps
// tb_map9_requester: directed bench for map9_requester with a small mapper model.
// Latency: n/a.
// Backpressure: exercises held rsp_ready and back-to-back commands.
module tb_map9_requester;

    localparam int START_CYC = 2;
    localparam int TO_CYC    = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    map9_requester_if sig();

    map9_requester #(
        .START_CYCLES   (START_CYC),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sig)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mapper model: drops done the cycle after start rises, raises it mdl_delay
    // cycles later with the result (mdl_delay 0 = never finishes).
    int         mdl_delay    = 40;
    int         mdl_cnt      = 0;
    logic       mdl_use_n    = 1'b0;
    logic       mdl_scramble = 1'b0;
    logic [8:0] mdl_dp       = 9'h0A5;
    logic       mdl_start_q  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sig.done = 1'b1;
            sig.dp   = 9'h000;
            mdl_cnt  = 0;
        end else if (sig.start && !mdl_start_q) begin
            sig.done = 1'b0;
            mdl_cnt  = mdl_delay;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                sig.done = 1'b1;
                sig.dp   = mdl_use_n ? (sig.N ^ 9'h155) : mdl_dp;
            end
        end
        if (mdl_scramble) begin
            sig.dp   = 9'($urandom);
            sig.done = 1'($urandom);
        end
        mdl_start_q = sig.start;
    end

    // Every start pulse must last exactly START_CYC cycles.
    int st_run    = 0;
    int st_pulses = 0;
    always @(negedge clk) begin
        if (sig.start) begin
            st_run++;
        end else if (st_run > 0) begin
            chk("start_run_len", st_run, START_CYC);
            st_pulses++;
            st_run = 0;
        end
    end

    // Present one command at a negedge and follow it until RESP (or budget).
    // lat = number of negedges after the accepting edge at which RESP is first seen.
    task automatic do_req(input string tag, input logic [8:0] n, input int budget, output int lat);
        int bad_rdy = 0;
        int bad_n   = 0;
        int nst     = 0;
        sig.cmd_valid = 1'b1;
        sig.cmd_n     = n;
        @(negedge clk);
        sig.cmd_valid = 1'b0;
        sig.cmd_n     = ~n;
        lat = 1;
        while (!sig.rsp_valid && lat < budget) begin
            if (sig.start)     nst++;
            if (sig.cmd_ready) bad_rdy++;
            if (sig.N != n)    bad_n++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_rdy_low"}, bad_rdy, 0);
        chk({tag, "_n_held"}, bad_n, 0);
        chk({tag, "_start_cyc"}, nst, START_CYC);
        chk({tag, "_rsp_valid"}, sig.rsp_valid, 1);
    endtask

    task automatic finish_rsp(input string tag);
        sig.rsp_ready = 1'b1;
        @(negedge clk);
        sig.rsp_ready = 1'b0;
        chk({tag, "_rsp_gone"}, sig.rsp_valid, 0);
        chk({tag, "_idle_rdy"}, sig.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         bad_v, bad_dp, bad_r, bad_n;
        int         idx, nrsp, rdy, p0;
        logic       acc;
        logic [8:0] held;
        logic [8:0] b2b_n  [2];
        logic [8:0] b2b_exp[2];
        logic [8:0] got    [2];

        sig.cmd_valid = 1'b0;
        sig.cmd_n     = 9'h000;
        sig.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_cmd_ready", sig.cmd_ready, 1);
        chk("rst_start", sig.start, 0);
        chk("rst_N", sig.N, 0);
        chk("rst_rsp_valid", sig.rsp_valid, 0);
        chk("rst_rsp_dp", sig.rsp_dp, 0);
        chk("rst_rsp_timeout", sig.rsp_timeout, 0);

        // Basic request, presented on the first edge after release:
        // 2 START + 1 CLEAR, done rises 40 cycles after it fell -> RESP seen at negedge 42.
        rst = 1'b0;
        do_req("t1", 9'h123, 200, lat);
        chk("t1_lat", lat, 42);
        chk("t1_N", sig.N, 9'h123);
        chk("t1_rsp_dp", sig.rsp_dp, 9'h0A5);
        chk("t1_rsp_timeout", sig.rsp_timeout, 0);
        finish_rsp("t1");

        // Response held 10 cycles while dp/done churn and a new command waits.
        mdl_use_n = 1'b1;
        do_req("t2", 9'h0C3, 200, lat);
        chk("t2_lat", lat, 42);
        chk("t2_rsp_dp", sig.rsp_dp, 9'h196);
        held = 9'h196;
        mdl_scramble  = 1'b1;
        sig.cmd_valid = 1'b1;
        sig.cmd_n     = 9'h0F0;
        bad_v = 0; bad_dp = 0; bad_r = 0; bad_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!sig.rsp_valid)        bad_v++;
            if (sig.rsp_dp != held)    bad_dp++;
            if (sig.cmd_ready)         bad_r++;
            if (sig.N != 9'h0C3)       bad_n++;
        end
        chk("t2_hold_valid", bad_v, 0);
        chk("t2_hold_dp", bad_dp, 0);
        chk("t2_hold_no_accept", bad_r, 0);
        chk("t2_hold_N", bad_n, 0);
        mdl_scramble  = 1'b0;
        sig.cmd_valid = 1'b0;
        finish_rsp("t2");

        // Back-to-back commands with rsp_ready tied high.
        b2b_n[0] = 9'h011; b2b_exp[0] = 9'h144;
        b2b_n[1] = 9'h1F0; b2b_exp[1] = 9'h0A5;
        got[0] = 9'h000; got[1] = 9'h000;
        p0 = st_pulses;
        sig.rsp_ready = 1'b1;
        sig.cmd_valid = 1'b1;
        sig.cmd_n     = b2b_n[0];
        idx = 0; nrsp = 0; rdy = 0;
        for (int c = 0; c < 400 && nrsp < 2; c++) begin
            acc = sig.cmd_ready && sig.cmd_valid;
            if (sig.cmd_ready) rdy++;
            if (sig.rsp_valid) begin
                got[nrsp] = sig.rsp_dp;
                nrsp++;
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 2) sig.cmd_n = b2b_n[idx];
                else         sig.cmd_valid = 1'b0;
            end
        end
        sig.rsp_ready = 1'b0;
        sig.cmd_valid = 1'b0;
        chk("t3_rsp_count", nrsp, 2);
        chk("t3_rsp0", got[0], b2b_exp[0]);
        chk("t3_rsp1", got[1], b2b_exp[1]);
        chk("t3_ready_cycles", rdy, 2);
        chk("t3_start_pulses", st_pulses - p0, 2);

        // Reset in BUSY: outputs drop at once, the request leaves no response.
        mdl_use_n = 1'b0;
        mdl_dp    = 9'h0A5;
        sig.cmd_valid = 1'b1;
        sig.cmd_n     = 9'h0AA;
        @(negedge clk);
        sig.cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("t4_busy_rdy", sig.cmd_ready, 0);
        chk("t4_busy_N", sig.N, 9'h0AA);
        #1 rst = 1'b1;
        #1;
        chk("t4_rst_start", sig.start, 0);
        chk("t4_rst_N", sig.N, 0);
        chk("t4_rst_rsp_valid", sig.rsp_valid, 0);
        chk("t4_rst_rsp_dp", sig.rsp_dp, 0);
        chk("t4_rst_rsp_timeout", sig.rsp_timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        bad_v = 0; bad_r = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sig.rsp_valid)  bad_v++;
            if (!sig.cmd_ready) bad_r++;
        end
        chk("t4_no_rsp", bad_v, 0);
        chk("t4_idle_rdy", bad_r, 0);
        chk("t4_idle_rsp_dp", sig.rsp_dp, 0);

        // Fresh request after the abort completes normally.
        mdl_dp = 9'h07E;
        do_req("t5", 9'h155, 200, lat);
        chk("t5_lat", lat, 42);
        chk("t5_rsp_dp", sig.rsp_dp, 9'h07E);
        chk("t5_rsp_timeout", sig.rsp_timeout, 0);
        finish_rsp("t5");

`ifdef MAP9_REQUESTER_TIMEOUT_EN
        // Mapper never finishes: CLEAR entered 2 edges after accept, abort 100 edges later
        // -> RESP seen at negedge 103 with a zero result.
        mdl_delay = 0;
        do_req("t6", 9'h0F0, 300, lat);
        chk("t6_lat", lat, 103);
        chk("t6_rsp_timeout", sig.rsp_timeout, 1);
        chk("t6_rsp_dp", sig.rsp_dp, 0);
        finish_rsp("t6");

        // done arrives on the expiry edge: the result wins.
        mdl_delay = 101;
        mdl_dp    = 9'h1C7;
        do_req("t7", 9'h033, 300, lat);
        chk("t7_lat", lat, 103);
        chk("t7_rsp_timeout", sig.rsp_timeout, 0);
        chk("t7_rsp_dp", sig.rsp_dp, 9'h1C7);
        finish_rsp("t7");

        // done one cycle too late: timeout.
        mdl_delay = 102;
        do_req("t8", 9'h034, 300, lat);
        chk("t8_lat", lat, 103);
        chk("t8_rsp_timeout", sig.rsp_timeout, 1);
        chk("t8_rsp_dp", sig.rsp_dp, 0);
        finish_rsp("t8");
`else
        // No timer: a slow mapper (well past TO_CYC) is simply waited for.
        mdl_delay = 250;
        mdl_dp    = 9'h1C7;
        do_req("t6", 9'h0F0, 400, lat);
        chk("t6_lat", lat, 252);
        chk("t6_rsp_timeout", sig.rsp_timeout, 0);
        chk("t6_rsp_dp", sig.rsp_dp, 9'h1C7);
        finish_rsp("t6");
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/map9_requester.md
MAP9_REQUESTER -- requirements
Module: map9_requester

Interface
REQ-001 Parameter: START_CYCLES, default 2, number of cycles start is held high per request (legal 1..15).
REQ-002 Parameter: TIMEOUT_CYCLES, default 1023, cycles waited for done before abort (legal 16..65535).
REQ-003 clock  input  1  single clock; all flops rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  upstream request present.
REQ-006 cmd_ready  output  1  request accepted when cmd_valid & cmd_ready.
REQ-007 cmd_n  input  9  operand delivered to mapper.
REQ-008 start  output  1  mapper start strobe.
REQ-009 N  output  9  operand to mapper, registered.
REQ-010 done  input  1  mapper completion flag.
REQ-011 dp  input  9  mapper result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  result consumed when rsp_valid & rsp_ready.
REQ-014 rsp_dp  output  9  captured result.
REQ-015 rsp_timeout  output  1  result is a timeout abort.

Function
REQ-016 FSM states: IDLE, START, CLEAR, BUSY, RESP.
- Encoding is free.
REQ-017 IDLE: cmd_ready=1, start=0; on accept, N<=cmd_n, load start counter, go to START.
REQ-018 START: start=1 for exactly START_CYCLES cycles, then start=0, go to CLEAR.
- N is held stable from accept until RESP exits.
REQ-019 CLEAR: wait for done=0, the mapper acknowledging the new run, then go to BUSY.
REQ-020 BUSY: on first cycle with done=1, rsp_dp<=dp, rsp_timeout<=0, go to RESP.
REQ-021 RESP: rsp_valid=1; rsp_dp/rsp_timeout stable until handshake; on rsp_ready, go to IDLE.
REQ-022 cmd_ready SHALL be 0 in every state except IDLE.
- No request overlap, single outstanding request.
REQ-023 start SHALL be low for at least one cycle between consecutive requests.
- Guaranteed by a mandatory IDLE cycle, so the mapper's start edge detector always sees a rising edge.
REQ-024 Wait counter: 16 bits; cleared on entry to CLEAR; increments each cycle in CLEAR/BUSY; saturates.
REQ-025 Counter value reaching TIMEOUT_CYCLES in CLEAR or BUSY SHALL force RESP with rsp_dp=0 and rsp_timeout=1.
- This applies when the feature of REQ-030 is compiled in.
REQ-026 Simultaneous done=1 and timeout in BUSY: done wins, normal result.
REQ-027 rsp_ready high outside RESP SHALL be ignored.
- done or dp changing outside CLEAR/BUSY SHALL be ignored.

Reset
REQ-028 Reset SHALL force, asynchronously:
- IDLE state
- start=0, N=0
- cmd_ready=1 after release
- rsp_valid=0, rsp_dp=0, rsp_timeout=0
- wait counter=0
REQ-029 Reset asserted mid-request SHALL abandon the request with no response.
- First cmd accept is possible on the first edge after deassertion.

Configuration
REQ-030 Macro MAP9_REQUESTER_TIMEOUT_EN.
- Defined: wait counter and timeout abort present per REQ-024/025.
- Undefined: counter removed; CLEAR/BUSY wait indefinitely; rsp_timeout tied 0.

Structure
REQ-031 Shared package map9_pkg SHALL hold:
- MAP9_N_W=9, MAP9_DP_W=9
- the requester state enum type
- the timeout counter width constant 16
REQ-032 One sub-module, map9_wait_timer: saturating wait counter with clear/enable/expired.
- Instantiated only under MAP9_REQUESTER_TIMEOUT_EN.

Verification
REQ-033 Mapper model, done low 1 cycle after start then high 40 cycles later with dp=9'h0A5; cmd_n=9'h123 -> N=9'h123, start high 2 cycles, rsp_dp=9'h0A5, rsp_timeout=0.
REQ-034 Back-to-back cmds with rsp_ready tied 1 -> start low >=1 cycle between pulses; two responses in order; cmd_ready=0 throughout each request.
REQ-035 Model never raises done, TIMEOUT_CYCLES=100 -> rsp_valid with rsp_timeout=1, rsp_dp=0 exactly 100 cycles after CLEAR entry; next cmd accepted.
REQ-036 rsp_ready held 0 for 10 cycles in RESP while dp changes -> rsp_dp stable, rsp_valid stays 1, no new cmd accepted.
REQ-037 reset pulsed during BUSY -> all outputs to reset values immediately, no response; fresh request completes normally.
REQ-038 done rises on the same cycle the timeout expires -> normal result, rsp_timeout=0.
